ble_adv_scheduler: RTL

- Sequences BLE advertising events. Each event transmits one packet on every enabled advertising channel (37, 38, 39), in ascending order.
- Drives the packet generator's start/enable and the modulator's channel index.
- Inserts an inter-frame gap between packets of one event and the advertising interval between events.
- Sits between the top-level configuration registers and the packetGenerator/FSK modulator datapath.

---
 rtl/ble_adv_scheduler_pkg.sv | 38 +++
 rtl/ble_adv_scheduler_if.sv | 31 +++
 rtl/ble_down_timer.sv | 29 ++
 rtl/ble_adv_scheduler.sv | 162 ++++++++++++++++
 4 files changed

// File: rtl/ble_adv_scheduler_pkg.sv
// Shared constants, state encoding and channel-mask helpers for the BLE
// advertising scheduler.
package ble_adv_scheduler_pkg;

  localparam int unsigned INTERVAL_W_DEF = 16;
  localparam int unsigned CNT_W_DEF      = 16;
  localparam int unsigned IFS_CYCLES_DEF = 150;
  localparam int unsigned TX_TIMEOUT_DEF = 4096;

  localparam int unsigned CHAN_W = 6;
  localparam int unsigned MAP_W  = 3;

  localparam logic [CHAN_W-1:0] BLE_CH37 = 6'd37;
  localparam logic [CHAN_W-1:0] BLE_CH38 = 6'd38;
  localparam logic [CHAN_W-1:0] BLE_CH39 = 6'd39;

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_SELECT   = 3'd1,
    ST_TX       = 3'd2,
    ST_GAP      = 3'd3,
    ST_INTERVAL = 3'd4
  } adv_state_e;

  // Channel number of the lowest enabled entry in a channel mask.
  function automatic logic [CHAN_W-1:0] lowest_chan(input logic [MAP_W-1:0] map);
    logic [CHAN_W-1:0] ch;
    if (map[0])      ch = BLE_CH37;
    else if (map[1]) ch = BLE_CH38;
    else             ch = BLE_CH39;
    return ch;
  endfunction

  function automatic logic [MAP_W-1:0] clear_lowest(input logic [MAP_W-1:0] map);
    return map & (map - MAP_W'(1));
  endfunction

endpackage

// File: rtl/ble_adv_scheduler_if.sv
// Configuration, packet-generator handshake and status signals of the
// advertising scheduler.
interface ble_adv_scheduler_if
  import ble_adv_scheduler_pkg::*;
#(
  parameter int unsigned INTERVAL_W = INTERVAL_W_DEF,
  parameter int unsigned CNT_W      = CNT_W_DEF
);

  logic                  enable;
  logic [MAP_W-1:0]      chan_map;
  logic [INTERVAL_W-1:0] adv_interval;
  logic                  tx_done;
  logic                  pkt_start;
  logic [CHAN_W-1:0]     chan_idx;
  logic                  tx_active;
  logic                  evt_done;
  logic                  tx_err;
  logic [CNT_W-1:0]      event_count;

  modport master (
    input  enable, chan_map, adv_interval, tx_done,
    output pkt_start, chan_idx, tx_active, evt_done, tx_err, event_count
  );

  modport slave (
    output enable, chan_map, adv_interval, tx_done,
    input  pkt_start, chan_idx, tx_active, evt_done, tx_err, event_count
  );

endinterface

// File: rtl/ble_down_timer.sv
// Loadable down counter that saturates at zero; zero_c flags the tick on
// which the count is at, or is about to reach, zero.
module ble_down_timer #(
  parameter int unsigned W = 16
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load,
  input  logic [W-1:0] load_val,
  input  logic         en,
  output logic         zero_c
);

  logic [W-1:0] cnt_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt_q <= '0;
    end else if (load) begin
      cnt_q <= load_val;
    end else if (en && (cnt_q != '0)) begin
      cnt_q <= cnt_q - W'(1);
    end
  end

  // A count loaded with N therefore spans exactly N enabled cycles.
  assign zero_c = (cnt_q <= W'(1));

endmodule

// File: rtl/ble_adv_scheduler.sv
// Sequences BLE advertising events across channels 37/38/39 with an
// inter-frame gap between packets and an advertising interval between events.
module ble_adv_scheduler
  import ble_adv_scheduler_pkg::*;
#(
  parameter int unsigned INTERVAL_W = INTERVAL_W_DEF,
  parameter int unsigned IFS_CYCLES = IFS_CYCLES_DEF,
  parameter int unsigned TX_TIMEOUT = TX_TIMEOUT_DEF,
  parameter int unsigned CNT_W      = CNT_W_DEF
) (
  input logic                 clk,
  input logic                 rst,
  ble_adv_scheduler_if.master bus
);

  localparam int unsigned TO_W  = $clog2(TX_TIMEOUT + 1);
  localparam int unsigned GAP_W = $clog2(IFS_CYCLES + 1);

  adv_state_e            state_q, state_d;
  logic [MAP_W-1:0]      mask_q, mask_d;
  logic [INTERVAL_W-1:0] int_latch_q, int_latch_d;
  logic [CHAN_W-1:0]     chan_idx_q, chan_idx_d;
  logic                  pkt_start_q, pkt_start_d;
  logic                  tx_active_q, tx_active_d;
  logic                  evt_done_q, evt_done_d;
  logic                  tx_err_q, tx_err_d;
  logic [CNT_W-1:0]      event_count_q, event_count_d;

  logic to_load, gap_load, int_load;
  logic to_zero_c, gap_zero_c, int_zero_c;

  // TX watchdog, inter-frame gap and advertising interval timers.
  ble_down_timer #(.W(TO_W)) u_timeout (
    .clk      (clk),
    .rst      (rst),
    .load     (to_load),
    .load_val (TO_W'(TX_TIMEOUT)),
    .en       (state_q == ST_TX),
    .zero_c   (to_zero_c)
  );

  ble_down_timer #(.W(GAP_W)) u_gap (
    .clk      (clk),
    .rst      (rst),
    .load     (gap_load),
    .load_val (GAP_W'(IFS_CYCLES)),
    .en       (state_q == ST_GAP),
    .zero_c   (gap_zero_c)
  );

  ble_down_timer #(.W(INTERVAL_W)) u_interval (
    .clk      (clk),
    .rst      (rst),
    .load     (int_load),
    .load_val (int_latch_q),
    .en       (state_q == ST_INTERVAL),
    .zero_c   (int_zero_c)
  );

  // Next-state and next-output logic; outputs are registered from the
  // upcoming state so pkt_start is aligned with TX and chan_idx with SELECT.
  always_comb begin
    state_d       = state_q;
    mask_d        = mask_q;
    int_latch_d   = int_latch_q;
    chan_idx_d    = chan_idx_q;
    evt_done_d    = 1'b0;
    tx_err_d      = 1'b0;
    event_count_d = event_count_q;
    to_load       = 1'b0;
    gap_load      = 1'b0;
    int_load      = 1'b0;
    pkt_start_d   = 1'b0;
    tx_active_d   = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (bus.enable && (bus.chan_map != '0)) begin
          state_d     = ST_SELECT;
          chan_idx_d  = lowest_chan(bus.chan_map);
          mask_d      = clear_lowest(bus.chan_map);
          int_latch_d = (bus.adv_interval == '0) ? INTERVAL_W'(1) : bus.adv_interval;
        end
      end
      ST_SELECT: begin
        state_d = ST_TX;
        to_load = 1'b1;
      end
      ST_TX: begin
        if (bus.tx_done) begin
          if (mask_q == '0) begin
            state_d       = ST_INTERVAL;
            evt_done_d    = 1'b1;
            event_count_d = event_count_q + CNT_W'(1);
            int_load      = 1'b1;
          end else if (bus.enable) begin
            state_d  = ST_GAP;
            gap_load = 1'b1;
          end else begin
            state_d = ST_IDLE;
          end
        end else if (to_zero_c) begin
          state_d  = ST_IDLE;
          tx_err_d = 1'b1;
          mask_d   = '0;
        end
      end
      ST_GAP: begin
        if (!bus.enable) begin
          state_d = ST_IDLE;
        end else if (gap_zero_c) begin
          state_d    = ST_SELECT;
          chan_idx_d = lowest_chan(mask_q);
          mask_d     = clear_lowest(mask_q);
        end
      end
      ST_INTERVAL: begin
        if (!bus.enable || int_zero_c) begin
          state_d = ST_IDLE;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    pkt_start_d = (state_d == ST_TX);
    tx_active_d = (state_d != ST_IDLE);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q       <= ST_IDLE;
      mask_q        <= '0;
      int_latch_q   <= '0;
      chan_idx_q    <= BLE_CH37;
      pkt_start_q   <= 1'b0;
      tx_active_q   <= 1'b0;
      evt_done_q    <= 1'b0;
      tx_err_q      <= 1'b0;
      event_count_q <= '0;
    end else begin
      state_q       <= state_d;
      mask_q        <= mask_d;
      int_latch_q   <= int_latch_d;
      chan_idx_q    <= chan_idx_d;
      pkt_start_q   <= pkt_start_d;
      tx_active_q   <= tx_active_d;
      evt_done_q    <= evt_done_d;
      tx_err_q      <= tx_err_d;
      event_count_q <= event_count_d;
    end
  end

  assign bus.pkt_start   = pkt_start_q;
  assign bus.chan_idx    = chan_idx_q;
  assign bus.tx_active   = tx_active_q;
  assign bus.evt_done    = evt_done_q;
  assign bus.tx_err      = tx_err_q;
  assign bus.event_count = event_count_q;

endmodule
